// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell walks the operands LSB first,
// producing a WIDTH-bit result, carry/no-borrow and signed overflow after WIDTH cycles.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             sub_q;
    logic             c_int;

    logic last_bit;
    logic b_bit;
    logic s_bit;
    logic c_out;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign b_bit    = b_sh[0] ^ sub_q;
    assign s_bit    = a_sh[0] ^ b_bit ^ c_int;
    assign c_out    = (a_sh[0] & b_bit) | (c_int & (a_sh[0] ^ b_bit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // a_sh doubles as the result shift register: each sum bit enters at the
    // MSB as the consumed operand bit leaves at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            sub_q    <= 1'b0;
            c_int    <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        sub_q <= sub;
                        cnt   <= '0;
                        c_int <= sub;
                    end
                end
                RUN: begin
                    a_sh  <= {s_bit, a_sh[WIDTH-1:1]};
                    b_sh  <= b_sh >> 1;
                    c_int <= c_out;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        sum      <= {s_bit, a_sh[WIDTH-1:1]};
                        carry    <= c_out;
                        overflow <= c_int ^ c_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: WIDTH=8 instance for the main vectors,
// WIDTH=4 instance for the narrow-width wrap case.
module tb_serial_adder_n;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
    logic       overflow;
    logic       busy;
    logic       done;

    logic       start4;
    logic       sub4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [3:0] sum4;
    logic       carry4;
    logic       overflow4;
    logic       busy4;
    logic       done4;

    int vectors    = 0;
    int miscompares = 0;
    logic [7:0] exp_hold = 8'h00;

    serial_adder_n #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .sum(sum), .carry(carry), .overflow(overflow), .busy(busy), .done(done)
    );

    serial_adder_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .sum(sum4), .carry(carry4), .overflow(overflow4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation on the 8-bit instance; operands are scrambled right
    // after capture to show the operation uses only the latched values.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic ts, input logic [7:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        sub = 1'($urandom_range(0, 1));
        check({tag, "_busy"}, 64'(busy), 64'(1));
        check({tag, "_hold"}, 64'(sum), 64'(exp_hold));
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(8));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_carry"}, 64'(carry), 64'(ec));
        check({tag, "_ovf"}, 64'(overflow), 64'(eo));
        exp_hold = es;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
        check({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int n;
        int done_cnt;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        #1;
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_flags", 64'({carry, overflow, busy, done}), 64'(0));
        check("rst_sum4", 64'(sum4), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("zero",     8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op("ff_p_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("7f_p_01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("05_m_07",  8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("80_m_01",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("10_m_10",  8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("c3_p_5a",  8'hC3, 8'h5A, 1'b0, 8'h1D, 1'b1, 1'b0);

        // Second start three cycles into RUN must be dropped.
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                done_cnt++;
                check("ignore_sum", 64'(sum), 64'(8'h46));
                check("ignore_carry", 64'({carry, overflow}), 64'(0));
            end
            @(negedge clk);
        end
        check("ignore_done_count", 64'(done_cnt), 64'(1));
        check("ignore_idle", 64'(busy), 64'(0));
        exp_hold = 8'h46;

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_sum", 64'(sum), 64'(0));
        check("midrst_flags", 64'({carry, overflow}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", 64'(done_cnt), 64'(0));
        exp_hold = 8'h00;
        run_op("10_p_20",  8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // Narrow instance: 0xF + 0xF wraps to 0xE with carry.
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; sub4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w4_latency", 64'(n), 64'(4));
        check("w4_sum", 64'(sum4), 64'(4'hE));
        check("w4_carry", 64'(carry4), 64'(1));
        check("w4_ovf", 64'(overflow4), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: sub  input  1  mode select: 0 = a+b, 1 = a-b; captured with start.
REQ-006 Port: a  input  WIDTH  operand A; captured with start.
REQ-007 Port: b  input  WIDTH  operand B; captured with start.
REQ-008 Port: sum  output  WIDTH  result of the last completed operation.
REQ-009 Port: carry  output  1  carry out of MSB; in subtract mode 1 = no borrow (a >= b unsigned).
REQ-010 Port: overflow  output  1  signed two's-complement overflow of the last completed operation.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: done  output  1  one-cycle pulse marking result valid.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL latch a, b and sub, set bit counter to 0, set internal carry to sub, and move to RUN.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE with all outputs held.
REQ-016 In RUN, each rising edge SHALL process exactly one bit, LSB first, using one full-adder cell: operand-B bit inverted when sub=1, internal carry updated to the cell's carry out.
REQ-017 When the bit processed is bit WIDTH-1, the FSM SHALL move to DONE and load sum, carry and overflow in the same edge.
REQ-018 overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-020 Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH; throughput one operation per WIDTH+2 cycles.
REQ-021 start asserted in RUN or DONE SHALL be ignored; it is not queued, and a held start is accepted on the first edge in IDLE.
REQ-022 Changes on a, b, sub after capture SHALL NOT affect the operation in progress.
REQ-023 sum, carry, overflow SHALL hold their values from the last completed operation until the next DONE transition, including while busy.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH; carry SHALL be the only indication of unsigned wrap.

Reset
REQ-025 On rst_n=0, the block SHALL immediately, without waiting for clk, force state to IDLE, counter and internal carry to 0, sum to 0, carry, overflow, busy and done to 0.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation; no done pulse, and outputs read 0 after release.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where start=1.

Verification (WIDTH=8 unless stated)
REQ-028 a=0x00, b=0x00, sub=0, start one cycle -> done after 8 RUN edges; sum=0x00, carry=0, overflow=0.
REQ-029 a=0xFF, b=0x01, sub=0 -> sum=0x00, carry=1, overflow=0; a=0x7F, b=0x01 -> sum=0x80, carry=0, overflow=1.
REQ-030 a=0x05, b=0x07, sub=1 -> sum=0xFE, carry=0, overflow=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, carry=1, overflow=1.
REQ-031 start pulsed again 3 cycles into RUN with different operands -> ignored; exactly one done pulse; result equals the first operands.
REQ-032 rst_n low for one cycle mid-RUN -> busy, done, sum drop to 0 asynchronously; no done pulse; a following op 0x10+0x20 -> 0x30.
REQ-033 WIDTH=4: a=0xF, b=0xF, sub=0 -> sum=0xE, carry=1, overflow=0; done in the cycle after edge k+4.
